// File: rtl/ext_resp_pkg.sv
// Shared types and helpers for the external-access responder.
// The word-index helper keeps the byte-to-word mapping in one place.
package ext_resp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ext_resp_state_e;

  localparam int LAT_W = 4;
  typedef logic [LAT_W-1:0] lat_cnt_t;

  // Byte address to word index; the low byte-offset bits are dropped and the
  // result wraps modulo the array depth.
  function automatic int unsigned word_index(input logic [31:0] addr,
                                             input int unsigned off_bits,
                                             input int unsigned depth);
    return (int'(addr >> off_bits)) % depth;
  endfunction

endpackage

// File: rtl/ext_resp_mem.sv
// Backing store for the responder: asynchronous read port, bit-enabled write port.
// Contents are intentionally not reset.
module ext_resp_mem
  import ext_resp_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 6
) (
  input  logic                  clk,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  we,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_biten
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= (mem[wr_idx] & ~wr_biten) | (wr_data & wr_biten);
  end

endmodule

// File: rtl/ext_mem_responder.sv
// Answers regblock external req strobes with rd_ack/wr_ack after a fixed latency.
// One request in flight; extra requests while busy are dropped and flagged.
module ext_mem_responder
  import ext_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1,
  parameter int DEPTH      = (2**ADDR_WIDTH) / (DATA_WIDTH/8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  req_is_wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_biten,
  output logic                  rd_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_ack,
  output logic                  busy,
  output logic                  proto_err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam lat_cnt_t RD_CNT = lat_cnt_t'(RD_LATENCY - 1);
  localparam lat_cnt_t WR_CNT = lat_cnt_t'(WR_LATENCY - 1);

  ext_resp_state_e       state;
  lat_cnt_t              cnt;
  lat_cnt_t              load_cnt;
  logic                  is_wr_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] biten_q;
  logic [DATA_WIDTH-1:0] snap_q;
  logic [IDX_W-1:0]      req_idx;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_we;

  assign req_idx  = IDX_W'(word_index(32'(addr), OFF_W, DEPTH));
  assign load_cnt = req_is_wr ? WR_CNT : RD_CNT;
  // A reset landing in the ack cycle abandons the write as well.
  assign mem_we   = wr_ack & rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_ack    <= 1'b0;
      wr_ack    <= 1'b0;
      rd_data   <= '0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      rd_ack  <= 1'b0;
      wr_ack  <= 1'b0;
      rd_data <= '0;
      if (req && busy) proto_err <= 1'b1;
      case (state)
        IDLE: begin
          if (req) begin
            is_wr_q <= req_is_wr;
            idx_q   <= req_idx;
            wdata_q <= wr_data;
            biten_q <= wr_biten;
            snap_q  <= mem_rdata;
            cnt     <= load_cnt;
            state   <= WAIT;
            busy    <= 1'b1;
            if (load_cnt == '0) begin
              rd_ack  <= ~req_is_wr;
              wr_ack  <= req_is_wr;
              rd_data <= req_is_wr ? '0 : mem_rdata;
            end
          end
        end
        WAIT: begin
          // WAIT spans the whole busy window, ack cycle included.
          if (rd_ack || wr_ack) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - lat_cnt_t'(1);
            if (cnt == lat_cnt_t'(1)) begin
              rd_ack  <= ~is_wr_q;
              wr_ack  <= is_wr_q;
              rd_data <= is_wr_q ? '0 : snap_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ext_resp_mem #(
    .DEPTH     (DEPTH),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk     (clk),
    .rd_idx  (req_idx),
    .rd_data (mem_rdata),
    .we      (mem_we),
    .wr_idx  (idx_q),
    .wr_data (wdata_q),
    .wr_biten(biten_q)
  );

endmodule
